// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light conflict monitor: lamp codes,
// fault codes and the monitor state encoding.
package tl_pkg;

    localparam logic [1:0] LAMP_RED     = 2'b00;
    localparam logic [1:0] LAMP_YELLOW  = 2'b01;
    localparam logic [1:0] LAMP_GREEN   = 2'b10;
    localparam logic [1:0] LAMP_INVALID = 2'b11;

    localparam logic [2:0] FC_NONE      = 3'b000;
    localparam logic [2:0] FC_CONFLICT  = 3'b001;
    localparam logic [2:0] FC_INVALID   = 3'b010;
    localparam logic [2:0] FC_BAD_TRANS = 3'b011;
    localparam logic [2:0] FC_SHORT_YEL = 3'b100;

    typedef enum logic [1:0] {
        ST_MONITOR = 2'b00,
        ST_FAULT   = 2'b01,
        ST_RECOVER = 2'b10
    } mon_state_e;

    // A lamp is "lit" for conflict purposes whenever it is not RED
    function automatic logic is_lit(input logic [1:0] code);
        return code != LAMP_RED;
    endfunction

endpackage

// File: rtl/tl_phase_checker.sv
// Per-signal phase checker: remembers the last accepted lamp code and the
// length of the current YELLOW run, and flags invalid codes, illegal phase
// steps and a YELLOW phase that ended too early.
module tl_phase_checker
    import tl_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3
) (
    input  logic       clk_i,
    input  logic       clear_n_i,
    input  logic [1:0] code_i,
    input  logic       update_i,
    input  logic       restart_i,
    output logic       invalid_o,
    output logic       bad_trans_o,
    output logic       short_yellow_o
);

    localparam logic [7:0] MIN_YEL_C = 8'(MIN_YELLOW);

    logic [1:0] prev_q, prev_d;
    logic [7:0] ycnt_q, ycnt_d;

    // Next history: restart forces RED/zero, an accepted cycle records the code
    always_comb begin
        prev_d = prev_q;
        ycnt_d = ycnt_q;
        if (restart_i) begin
            prev_d = LAMP_RED;
            ycnt_d = 8'd0;
        end else if (update_i) begin
            prev_d = code_i;
            if (code_i == LAMP_YELLOW) begin
                ycnt_d = (ycnt_q == 8'hFF) ? 8'hFF : ycnt_q + 8'd1;
            end else begin
                ycnt_d = 8'd0;
            end
        end
    end

    // History registers
    always_ff @(posedge clk_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            prev_q <= LAMP_RED;
            ycnt_q <= 8'd0;
        end else begin
            prev_q <= prev_d;
            ycnt_q <= ycnt_d;
        end
    end

    assign invalid_o      = (code_i == LAMP_INVALID);
    assign bad_trans_o    = ((prev_q == LAMP_GREEN)  && (code_i == LAMP_RED))    ||
                            ((prev_q == LAMP_RED)    && (code_i == LAMP_YELLOW)) ||
                            ((prev_q == LAMP_YELLOW) && (code_i == LAMP_GREEN));
    assign short_yellow_o = (prev_q == LAMP_YELLOW) && (code_i == LAMP_RED) &&
                            (ycnt_q < MIN_YEL_C);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the light FSM and the lamp drivers. Forwards legal
// lamp codes one cycle late; on the first violation it latches the fault,
// blanks all lamps to RED with flashing, and waits for an acknowledge plus
// a sustained all-RED input before resuming.
module traffic_conflict_monitor
    import tl_pkg::*;
#(
    parameter int unsigned MIN_YELLOW     = 3,
    parameter int unsigned FLASH_HALF     = 4,
    parameter int unsigned RECOVER_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       clear_n_i,
    input  logic [1:0] ns_i,
    input  logic [1:0] sn_i,
    input  logic [1:0] ew_i,
    input  logic [1:0] we_i,
    input  logic       fault_ack_i,
    output logic [1:0] ns_o,
    output logic [1:0] sn_o,
    output logic [1:0] ew_o,
    output logic [1:0] we_o,
    output logic       flash_o,
    output logic       fault_o,
    output logic [2:0] fault_code_o,
    output logic [3:0] fault_src_o
);

    localparam logic [7:0] FLASH_LAST   = 8'(FLASH_HALF - 1);
    localparam logic [7:0] RECOVER_LAST = 8'(RECOVER_CYCLES - 1);

    // Bit 3..0 of every per-signal vector = NS, SN, EW, WE
    logic [7:0] codes;
    logic [3:0] lit, invalid, bad_trans, short_yel;
    logic       conflict;
    logic [2:0] det_code;
    logic [3:0] det_src;
    logic       upd, restart;

    mon_state_e state_q, state_d;
    logic [7:0] out_q, out_d;
    logic       flash_q, flash_d;
    logic       fault_q, fault_d;
    logic [2:0] code_q, code_d;
    logic [3:0] src_q, src_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic [7:0] rcnt_q, rcnt_d;

    assign codes = {ns_i, sn_i, ew_i, we_i};

    for (genvar g = 0; g < 4; g++) begin : g_chk
        assign lit[g] = is_lit(codes[2*g+1 -: 2]);

        tl_phase_checker #(
            .MIN_YELLOW(MIN_YELLOW)
        ) u_chk (
            .clk_i         (clk_i),
            .clear_n_i     (clear_n_i),
            .code_i        (codes[2*g+1 -: 2]),
            .update_i      (upd),
            .restart_i     (restart),
            .invalid_o     (invalid[g]),
            .bad_trans_o   (bad_trans[g]),
            .short_yellow_o(short_yel[g])
        );
    end

    // Priority encoder: conflict > invalid > bad transition > short yellow
    always_comb begin
        conflict = (lit[3] | lit[2]) & (lit[1] | lit[0]);
        det_code = FC_NONE;
        det_src  = 4'b0000;
        if (conflict) begin
            det_code = FC_CONFLICT;
            det_src  = lit;
        end else if (|invalid) begin
            det_code = FC_INVALID;
            det_src  = invalid;
        end else if (|bad_trans) begin
            det_code = FC_BAD_TRANS;
            det_src  = bad_trans;
        end else if (|short_yel) begin
            det_code = FC_SHORT_YEL;
            det_src  = short_yel;
        end
    end

    // Monitor FSM: next state, lamp outputs, fault latch, flash and recover counters
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        flash_d = flash_q;
        fault_d = fault_q;
        code_d  = code_q;
        src_d   = src_q;
        fcnt_d  = fcnt_q;
        rcnt_d  = rcnt_q;
        upd     = 1'b0;
        restart = 1'b0;

        if (state_q != ST_MONITOR) begin
            if (fcnt_q >= FLASH_LAST) begin
                fcnt_d  = 8'd0;
                flash_d = ~flash_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end

        case (state_q)
            ST_MONITOR: begin
                if (det_code != FC_NONE) begin
                    state_d = ST_FAULT;
                    out_d   = 8'h00;
                    fault_d = 1'b1;
                    code_d  = det_code;
                    src_d   = det_src;
                    flash_d = 1'b0;
                    fcnt_d  = 8'd0;
                    rcnt_d  = 8'd0;
                end else begin
                    out_d = codes;
                    upd   = 1'b1;
                end
            end
            ST_FAULT: begin
                out_d = 8'h00;
                if (fault_ack_i) begin
                    state_d = ST_RECOVER;
                    rcnt_d  = 8'd0;
                end
            end
            ST_RECOVER: begin
                out_d = 8'h00;
                if (codes == 8'h00) begin
                    if (rcnt_q >= RECOVER_LAST) begin
                        state_d = ST_MONITOR;
                        fault_d = 1'b0;
                        code_d  = FC_NONE;
                        src_d   = 4'b0000;
                        flash_d = 1'b1;
                        fcnt_d  = 8'd0;
                        rcnt_d  = 8'd0;
                        restart = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 8'd1;
                    end
                end else begin
                    rcnt_d = 8'd0;
                end
            end
            default: begin
                state_d = ST_MONITOR;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            state_q <= ST_MONITOR;
            out_q   <= 8'h00;
            flash_q <= 1'b1;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            src_q   <= 4'b0000;
            fcnt_q  <= 8'd0;
            rcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            flash_q <= flash_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            src_q   <= src_d;
            fcnt_q  <= fcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign ns_o         = out_q[7:6];
    assign sn_o         = out_q[5:4];
    assign ew_o         = out_q[3:2];
    assign we_o         = out_q[1:0];
    assign flash_o      = flash_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;
    assign fault_src_o  = src_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed and randomized bench for traffic_conflict_monitor against a
// behavioural model derived from the lamp-safety rules.
module tb_traffic_conflict_monitor;

    localparam int MINY = 3;
    localparam int FH   = 4;
    localparam int RC   = 8;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [1:0] ns, sn, ew, we;
    logic       ack;
    logic [1:0] ns_o, sn_o, ew_o, we_o;
    logic       flash_o, fault_o;
    logic [2:0] code_o;
    logic [3:0] src_o;

    int vectors = 0;
    int miscompares = 0;

    // Model state: mode 0 = normal, 1 = faulted, 2 = recovering
    int         m_mode;
    int         m_prev[4];
    int         m_ycnt[4];
    int         m_t;
    int         m_rz;
    int         cur[4];
    logic [1:0] e_out[4];
    logic       e_flash, e_fault;
    logic [2:0] e_code;
    logic [3:0] e_src;

    always #5 clk = ~clk;

    traffic_conflict_monitor #(
        .MIN_YELLOW(MINY), .FLASH_HALF(FH), .RECOVER_CYCLES(RC)
    ) dut (
        .clk_i(clk), .clear_n_i(clear_n),
        .ns_i(ns), .sn_i(sn), .ew_i(ew), .we_i(we),
        .fault_ack_i(ack),
        .ns_o(ns_o), .sn_o(sn_o), .ew_o(ew_o), .we_o(we_o),
        .flash_o(flash_o), .fault_o(fault_o),
        .fault_code_o(code_o), .fault_src_o(src_o)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_rz = 0;
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = 0; m_ycnt[i] = 0; e_out[i] = 2'b00;
        end
        e_flash = 1'b1; e_fault = 1'b0; e_code = 3'b000; e_src = 4'b0000;
    endtask

    task automatic model_step();
        logic [3:0] conf, inv, bad, shy;
        bit         any_a, any_b, all_red;
        int         pos;
        conf = '0; inv = '0; bad = '0; shy = '0;
        any_a = (cur[0] != 0) || (cur[1] != 0);
        any_b = (cur[2] != 0) || (cur[3] != 0);
        all_red = !any_a && !any_b;
        if (m_mode == 0) begin
            for (int i = 0; i < 4; i++) begin
                pos = 3 - i;
                if (cur[i] != 0) conf[pos] = 1'b1;
                if (cur[i] == 3) inv[pos] = 1'b1;
                if ((m_prev[i] == 2 && cur[i] == 0) || (m_prev[i] == 0 && cur[i] == 1) ||
                    (m_prev[i] == 1 && cur[i] == 2)) bad[pos] = 1'b1;
                if (m_prev[i] == 1 && cur[i] == 0 && m_ycnt[i] < MINY) shy[pos] = 1'b1;
            end
            e_code = 3'b000; e_src = 4'b0000;
            if (any_a && any_b) begin e_code = 3'b001; e_src = conf; end
            else if (inv != 0)  begin e_code = 3'b010; e_src = inv;  end
            else if (bad != 0)  begin e_code = 3'b011; e_src = bad;  end
            else if (shy != 0)  begin e_code = 3'b100; e_src = shy;  end
            if (e_code != 3'b000) begin
                m_mode = 1; e_fault = 1'b1; e_flash = 1'b0; m_t = 0;
                for (int i = 0; i < 4; i++) e_out[i] = 2'b00;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    e_out[i]  = 2'(cur[i]);
                    m_prev[i] = cur[i];
                    m_ycnt[i] = (cur[i] == 1) ? ((m_ycnt[i] >= 255) ? 255 : m_ycnt[i] + 1) : 0;
                end
            end
        end else begin
            m_t++;
            e_flash = ((m_t / FH) % 2) == 1;
            if (m_mode == 1) begin
                if (ack) begin m_mode = 2; m_rz = 0; end
            end else if (all_red) begin
                m_rz++;
                if (m_rz == RC) begin
                    model_reset();
                end
            end else begin
                m_rz = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ns"},    {2'b00, ns_o},    {2'b00, e_out[0]});
        chk({tag, "_sn"},    {2'b00, sn_o},    {2'b00, e_out[1]});
        chk({tag, "_ew"},    {2'b00, ew_o},    {2'b00, e_out[2]});
        chk({tag, "_we"},    {2'b00, we_o},    {2'b00, e_out[3]});
        chk({tag, "_flash"}, {3'b000, flash_o}, {3'b000, e_flash});
        chk({tag, "_fault"}, {3'b000, fault_o}, {3'b000, e_fault});
        chk({tag, "_code"},  {1'b0, code_o},   {1'b0, e_code});
        chk({tag, "_src"},   src_o,            e_src);
    endtask

    task automatic step(input string tag, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d, input logic k);
        ns = a; sn = b; ew = c; we = d; ack = k;
        cur[0] = int'(a); cur[1] = int'(b); cur[2] = int'(c); cur[3] = int'(d);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic recover(input string tag);
        step({tag, "_ack"}, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
        for (int i = 0; i < RC; i++) step({tag, "_rec"}, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    endtask

    function automatic logic [1:0] rnd_code();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 7) return 2'b00;
        if (r < 11) return 2'b10;
        if (r < 15) return 2'b01;
        return 2'b11;
    endfunction

    initial begin
        logic [1:0] rv[4];
        clear_n = 1'b1; ns = 0; sn = 0; ew = 0; we = 0; ack = 0;
        for (int i = 0; i < 4; i++) cur[i] = 0;
        model_reset();
        #1 clear_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");
        @(negedge clk); clear_n = 1'b1;

        // Legal cycle on axis A then axis B
        step("t1", 2'd2, 2'd2, 2'd0, 2'd0, 1'b0);
        chk("t1_latency", {2'b00, ns_o}, 4'h2);
        for (int i = 0; i < 3; i++) step("t1", 2'd1, 2'd1, 2'd0, 2'd0, 1'b0);
        step("t1", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("t1", 2'd0, 2'd0, 2'd2, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) step("t1", 2'd0, 2'd0, 2'd1, 2'd1, 1'b0);
        step("t1", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        chk("t1_nofault", {3'b000, fault_o}, 4'h0);

        // Cross-axis conflict, then flash cadence
        step("t2", 2'd2, 2'd0, 2'd2, 2'd0, 1'b0);
        chk("t2_code", {1'b0, code_o}, 4'h1);
        chk("t2_src", src_o, 4'b1010);
        for (int i = 0; i < 4; i++) step("t2_flash", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        chk("t2_flash_on", {3'b000, flash_o}, 4'h1);
        for (int i = 0; i < 4; i++) step("t2_flash", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("t2_ignored", 2'd3, 2'd0, 2'd2, 2'd0, 1'b0);
        chk("t2_first_kept", {1'b0, code_o}, 4'h1);

        // Recover with an interruption of the all-RED run
        step("t5_ack", 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) step("t5", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        step("t5_break", 2'd2, 2'd0, 2'd0, 2'd0, 1'b0);
        for (int i = 0; i < 7; i++) step("t5", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        chk("t5_still_fault", {3'b000, fault_o}, 4'h1);
        step("t5_exit", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        chk("t5_fault_clr", {3'b000, fault_o}, 4'h0);
        chk("t5_flash_on", {3'b000, flash_o}, 4'h1);

        // Direct GREEN->RED, then with an invalid code in the same cycle
        step("t3a", 2'd0, 2'd2, 2'd0, 2'd0, 1'b0);
        step("t3a", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        chk("t3a_code", {1'b0, code_o}, 4'h3);
        chk("t3a_src", src_o, 4'b0100);
        recover("t3a");
        step("t3b", 2'd0, 2'd2, 2'd0, 2'd0, 1'b0);
        step("t3b", 2'd0, 2'd0, 2'd0, 2'd3, 1'b0);
        chk("t3b_code", {1'b0, code_o}, 4'h2);
        chk("t3b_src", src_o, 4'b0001);
        recover("t3b");

        // Yellow held two cycles only
        step("t4", 2'd2, 2'd0, 2'd0, 2'd0, 1'b0);
        step("t4", 2'd1, 2'd0, 2'd0, 2'd0, 1'b0);
        step("t4", 2'd1, 2'd0, 2'd0, 2'd0, 1'b0);
        step("t4", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        chk("t4_code", {1'b0, code_o}, 4'h4);
        chk("t4_src", src_o, 4'b1000);

        // Asynchronous clear in the middle of a fault
        step("t6", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        #3 clear_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(negedge clk); #2 clear_n = 1'b1;
        step("t6_after", 2'd2, 2'd2, 2'd0, 2'd0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 4; i++) rv[i] = 2'(cur[i]);
        for (int n = 0; n < 700; n++) begin
            if (m_mode == 0) begin
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 3) == 0) rv[i] = rnd_code();
                step("rnd", rv[0], rv[1], rv[2], rv[3], 1'($urandom_range(0, 1)));
            end else begin
                for (int i = 0; i < 4; i++)
                    rv[i] = ($urandom_range(0, 15) == 0) ? rnd_code() : 2'b00;
                step("rnd", rv[0], rv[1], rv[2], rv[3], $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
